uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/flex_pts_sr.sv | 45 ++++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; vacated bits fill with ones so an idle
// or exhausted register presents a mark level.
module flex_pts_sr #(
  parameter int NUM_BITS  = 4,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                load_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr_q;
  logic [NUM_BITS-1:0] sr_d;

  // Load takes priority over shift.
  always_comb begin
    sr_d = sr_q;
    if (load_enable) begin
      sr_d = parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        sr_d = {sr_q[NUM_BITS-2:0], 1'b1};
      end else begin
        sr_d = {1'b1, sr_q[NUM_BITS-1:1]};
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= {NUM_BITS{1'b1}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB-first payload, stop bit, with a
// one-cycle DONE state that also accepts the next frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          serial_q, serial_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_s;
  logic          shift_s;
  logic          sr_bit_s;
  logic          wrap_s;

  assign wrap_s = (cnt_q == CW'(CLKS_PER_BIT - 1));

  flex_pts_sr #(
    .NUM_BITS (DATA_BITS),
    .SHIFT_MSB(1'b0)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_s),
    .load_enable (load_s),
    .parallel_in (tx_data),
    .serial_out  (sr_bit_s)
  );

  // Next-state and registered-output logic. The line value for the next bit
  // is taken from the shifter in the same cycle the shifter advances.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (tx_start) begin
          state_d  = START;
          cnt_d    = '0;
          idx_d    = '0;
          load_s   = 1'b1;
          serial_d = START_BIT;
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
          serial_d = STOP_BIT;
          busy_d   = 1'b0;
        end
      end
      START: begin
        if (wrap_s) begin
          state_d  = DATA;
          cnt_d    = '0;
          serial_d = sr_bit_s;
          shift_s  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (wrap_s) begin
          cnt_d = '0;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            state_d  = STOP;
            serial_d = STOP_BIT;
          end else begin
            idx_d    = idx_q + IW'(1);
            serial_d = sr_bit_s;
            shift_s  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (wrap_s) begin
          state_d  = DONE;
          cnt_d    = '0;
          serial_d = STOP_BIT;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = STOP_BIT;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset idles the line high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      serial_q <= STOP_BIT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx with a per-cycle frame model and a
// mid-bit sampling receiver for loopback.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk, n_rst;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic       busy, done, ser;
  logic       busy2, done2, ser2;

  int checks = 0;
  int errors = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(busy), .tx_done(done), .serial_out(ser)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut2 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data2), .tx_start(tx_start2),
    .tx_busy(busy2), .tx_done(done2), .serial_out(ser2)
  );

  always #5 clk = ~clk;

  // Receiver: detect start bit, then sample each bit near its middle.
  initial begin
    logic [8:0] f;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && ser === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          repeat (CPB) @(negedge clk);
          f[i] = ser;
        end
        rx_q.push_back(f);
      end
    end
  end

  // Expected line level k cycles after the accepting edge.
  function automatic logic exp_line(input logic [7:0] d, input int cpb, input int k);
    int b;
    b = (k - 1) / cpb;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got %h exp %h", tag, k, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 1 of a frame; returns at cycle n+2.
  task automatic check_frame(input logic [7:0] d, input int cpb, input bit use2, input bit inject);
    int n;
    n = 10 * cpb;
    for (int k = 1; k <= n + 1; k++) begin
      chk("line", k, {8'h00, use2 ? ser2 : ser}, {8'h00, exp_line(d, cpb, k)});
      chk("busy", k, {8'h00, use2 ? busy2 : busy}, {8'h00, k <= n});
      chk("done", k, {8'h00, use2 ? done2 : done}, {8'h00, k == n + 1});
      if (inject) begin
        if (k == 35) begin tx_start = 1'b1; tx_data = 8'h3C; end
        if (k == 40) tx_start = 1'b0;
        if (k == 60) tx_start = 1'b1;
        if (k == 61) tx_start = 1'b0;
        if (k == 62) tx_data = 8'hFF;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input int n, input bit use2);
    for (int k = 0; k < n; k++) begin
      chk("idle_line", k, {8'h00, use2 ? ser2 : ser}, 9'h001);
      chk("idle_busy", k, {8'h00, use2 ? busy2 : busy}, 9'h000);
      chk("idle_done", k, {8'h00, use2 ? done2 : done}, 9'h000);
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic check_rx();
    chk("rx_count", 0, 9'(rx_q.size()), 9'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      chk("rx_frame", i, rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    logic [7:0] r;
    clk = 1'b0; n_rst = 1'b0;
    tx_start = 1'b0; tx_start2 = 1'b0; tx_data = 8'h00; tx_data2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_line", 0, {8'h00, ser}, 9'h001);
    chk("rst_busy", 0, {8'h00, busy}, 9'h000);
    chk("rst_done", 0, {8'h00, done}, 9'h000);
    chk("rst_line2", 0, {8'h00, ser2}, 9'h001);
    n_rst = 1'b1;
    check_idle(5, 1'b0);

    // Single frame
    send(8'hA5); exp_q.push_back({1'b1, 8'hA5});
    check_frame(8'hA5, CPB, 1'b0, 1'b0);
    check_idle(5, 1'b0);

    // Back-to-back with tx_start held high
    @(negedge clk);
    tx_data = 8'h00; tx_start = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    check_frame(8'h00, CPB, 1'b0, 1'b0);
    tx_start = 1'b0;
    check_frame(8'hFF, CPB, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 8'h00}); exp_q.push_back({1'b1, 8'hFF});
    check_idle(5, 1'b0);

    // Busy-ignore: start pulses and new data mid-frame
    send(8'h81); exp_q.push_back({1'b1, 8'h81});
    check_frame(8'h81, CPB, 1'b0, 1'b1);
    check_idle(30, 1'b0);

    // Random payloads
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(0, 255));
      send(r); exp_q.push_back({1'b1, r});
      check_frame(r, CPB, 1'b0, 1'b0);
    end

    // Loopback payloads
    send(8'hC3); exp_q.push_back({1'b1, 8'hC3});
    check_frame(8'hC3, CPB, 1'b0, 1'b0);
    send(8'h7E); exp_q.push_back({1'b1, 8'h7E});
    check_frame(8'h7E, CPB, 1'b0, 1'b0);
    check_idle(5, 1'b0);
    check_rx();

    // Mid-frame reset during data bit 4 (cycles 51..60)
    send(8'h55);
    repeat (54) @(negedge clk);
    chk("pre_rst_line", 55, {8'h00, ser}, {8'h00, exp_line(8'h55, CPB, 55)});
    n_rst = 1'b0;
    #1;
    chk("async_line", 0, {8'h00, ser}, 9'h001);
    chk("async_busy", 0, {8'h00, busy}, 9'h000);
    chk("async_done", 0, {8'h00, done}, 9'h000);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    check_idle(120, 1'b0);
    rx_q.delete(); exp_q.delete();
    send(8'h55); exp_q.push_back({1'b1, 8'h55});
    check_frame(8'h55, CPB, 1'b0, 1'b0);
    check_idle(5, 1'b0);
    check_rx();

    // Minimum bit period on the second instance
    @(negedge clk);
    tx_data2 = 8'h01; tx_start2 = 1'b1;
    @(negedge clk);
    tx_start2 = 1'b0;
    check_frame(8'h01, 2, 1'b1, 1'b0);
    check_idle(5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
